// File: rtl/joypad_port.sv
`default_nettype none
// ============================================================================
//  Module   : joypad_port
//  Purpose  : NES-style $4016/$4017 controller port. Two standard pads (or a
//             power pad on port 1) are latched while strobe is high and then
//             read out serially, one bit per CPU read pulse.
//  Revision : 1.0  initial release
// ============================================================================
module joypad_port #(
  parameter logic FILL_BIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        strobe,
  input  logic        rd0,
  input  logic        rd1,
  input  logic [7:0]  joy0,
  input  logic [7:0]  joy1,
  input  logic [11:0] powerpad,
  input  logic        powerpad_en,
  output logic        port0_d0,
  output logic        port1_d0,
  output logic        port1_d3,
  output logic        port1_d4
);

  localparam logic [3:0] CNT_MAX = 4'd8;

  // Both ports see the same strobe line, so they share one LOAD/SHIFT state.
  typedef enum logic [0:0] {
    ST_SHIFT = 1'b0,
    ST_LOAD  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        load_en;
  logic        shift0_en;
  logic        shift1_en;

  logic [7:0]  sr0;
  logic [7:0]  sr1;
  logic [7:0]  sr3;
  logic [7:0]  sr4;
  logic [3:0]  cnt0;
  logic [3:0]  cnt1;

  logic [7:0]  sr1_load;
  logic [7:0]  sr3_load;
  logic [7:0]  sr4_load;
  logic [7:0]  sr0_shift;
  logic [7:0]  sr1_shift;
  logic [7:0]  sr3_shift;
  logic [7:0]  sr4_shift;

  // State register: tracks strobe one clock late.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_SHIFT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-port enables; a held strobe always reloads, and a
  // read while strobe is high never shifts.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    shift0_en = 1'b0;
    shift1_en = 1'b0;
    unique case (state)
      ST_LOAD:  if (!strobe) state_nxt = ST_SHIFT;
      ST_SHIFT: if (strobe)  state_nxt = ST_LOAD;
      default:  state_nxt = ST_SHIFT;
    endcase
    if (strobe) begin
      load_en = 1'b1;
    end else begin
      shift0_en = rd0;
      shift1_en = rd1;
    end
  end

  // Parallel-load images; the power pad's wiring scrambles button order
  // across the D3 and D4 lines.
  always_comb begin
    sr1_load = powerpad_en ? 8'h00 : joy1;
    sr3_load = 8'h00;
    sr4_load = 8'h00;
    if (powerpad_en) begin
      sr3_load = {powerpad[6], powerpad[10], powerpad[9], powerpad[5],
                  powerpad[8], powerpad[4],  powerpad[0], powerpad[1]};
      sr4_load = {{4{FILL_BIT}}, powerpad[7], powerpad[11],
                  powerpad[2], powerpad[3]};
    end
  end

  // Shift images; once a port has delivered all eight bits the register is
  // simply refilled with FILL_BIT so the line stays parked there.
  always_comb begin
    sr0_shift = (cnt0 == CNT_MAX) ? {8{FILL_BIT}} : {FILL_BIT, sr0[7:1]};
    sr1_shift = (cnt1 == CNT_MAX) ? {8{FILL_BIT}} : {FILL_BIT, sr1[7:1]};
    sr3_shift = (cnt1 == CNT_MAX) ? {8{FILL_BIT}} : {FILL_BIT, sr3[7:1]};
    sr4_shift = (cnt1 == CNT_MAX) ? {8{FILL_BIT}} : {FILL_BIT, sr4[7:1]};
  end

  // Port 0 shift register and saturating read counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr0  <= {8{FILL_BIT}};
      cnt0 <= 4'd0;
    end else if (load_en) begin
      sr0  <= joy0;
      cnt0 <= 4'd0;
    end else if (shift0_en) begin
      sr0  <= sr0_shift;
      if (cnt0 != CNT_MAX) cnt0 <= cnt0 + 4'd1;
    end
  end

  // Port 1 shift registers (D0, D3, D4 move together) and read counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr1  <= {8{FILL_BIT}};
      sr3  <= {8{FILL_BIT}};
      sr4  <= {8{FILL_BIT}};
      cnt1 <= 4'd0;
    end else if (load_en) begin
      sr1  <= sr1_load;
      sr3  <= sr3_load;
      sr4  <= sr4_load;
      cnt1 <= 4'd0;
    end else if (shift1_en) begin
      sr1  <= sr1_shift;
      sr3  <= sr3_shift;
      sr4  <= sr4_shift;
      if (cnt1 != CNT_MAX) cnt1 <= cnt1 + 4'd1;
    end
  end

  // Serial data is the register LSB, visible in the same cycle as the read.
  assign port0_d0 = sr0[0];
  assign port1_d0 = sr1[0];
  assign port1_d3 = sr3[0];
  assign port1_d4 = sr4[0];

endmodule
`default_nettype wire

// File: tb/tb_joypad_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_joypad_port
//  Purpose  : Scoreboard bench for joypad_port. The driver predicts each
//             cycle's serial outputs from a button-list model and queues
//             them; a monitor pops and compares every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_joypad_port;

  localparam logic FILL = 1'b1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        strobe;
  logic        rd0;
  logic        rd1;
  logic [7:0]  joy0;
  logic [7:0]  joy1;
  logic [11:0] powerpad;
  logic        powerpad_en;
  logic        port0_d0;
  logic        port1_d0;
  logic        port1_d3;
  logic        port1_d4;

  joypad_port #(.FILL_BIT(FILL)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .strobe      (strobe),
    .rd0         (rd0),
    .rd1         (rd1),
    .joy0        (joy0),
    .joy1        (joy1),
    .powerpad    (powerpad),
    .powerpad_en (powerpad_en),
    .port0_d0    (port0_d0),
    .port1_d0    (port1_d0),
    .port1_d3    (port1_d3),
    .port1_d4    (port1_d4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic p0;
    logic p1;
    logic d3;
    logic d4;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle_no    = 0;

  // Reference model: the latched report of each line as a list of bits in
  // the order they are read out, plus how many reads each port has seen.
  logic m0 [0:7];
  logic m1 [0:7];
  logic m3 [0:7];
  logic m4 [0:7];
  int   idx0;
  int   idx1;
  // Power-pad button numbers (1..12) read out on D3 and D4; 0 = filler.
  int   d3_btn [0:7] = '{2, 1, 5, 9, 6, 10, 11, 7};
  int   d4_btn [0:7] = '{4, 3, 12, 8, 0, 0, 0, 0};

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m0[i] = FILL; m1[i] = FILL; m3[i] = FILL; m4[i] = FILL;
    end
    idx0 = 8;
    idx1 = 8;
  endfunction

  function automatic void model_load();
    for (int i = 0; i < 8; i++) begin
      m0[i] = joy0[i];
      m1[i] = powerpad_en ? 1'b0 : joy1[i];
      m3[i] = powerpad_en ? powerpad[d3_btn[i] - 1] : 1'b0;
      if (!powerpad_en)      m4[i] = 1'b0;
      else if (d4_btn[i] == 0) m4[i] = FILL;
      else                   m4[i] = powerpad[d4_btn[i] - 1];
    end
    idx0 = 0;
    idx1 = 0;
  endfunction

  // One clock: predict the outputs visible now, then advance the model
  // across the coming rising edge.
  task automatic step();
    exp_t e;
    e.p0  = (idx0 < 8) ? m0[idx0] : FILL;
    e.p1  = (idx1 < 8) ? m1[idx1] : FILL;
    e.d3  = (idx1 < 8) ? m3[idx1] : FILL;
    e.d4  = (idx1 < 8) ? m4[idx1] : FILL;
    e.cyc = cycle_no;
    sb.push_back(e);
    if (!reset_n) begin
      model_reset();
    end else if (strobe) begin
      model_load();
    end else begin
      if (rd0 && idx0 < 8) idx0++;
      if (rd1 && idx1 < 8) idx1++;
    end
    cycle_no++;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp, input int cyc);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are combinational and always presented, so every
  // queued prediction is checked mid-cycle, well clear of the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("port0_d0", port0_d0, e.p0, e.cyc);
        chk("port1_d0", port1_d0, e.p1, e.cyc);
        chk("port1_d3", port1_d3, e.d3, e.cyc);
        chk("port1_d4", port1_d4, e.d4, e.cyc);
      end
    end
  end

  task automatic idle_inputs();
    strobe = 1'b0; rd0 = 1'b0; rd1 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; strobe = 1'b0; rd0 = 1'b0; rd1 = 1'b0;
    joy0 = 8'h00; joy1 = 8'h00; powerpad = 12'h000; powerpad_en = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    // Post-reset idle: all lines at FILL, reads keep them there.
    step();
    rd0 = 1'b1; rd1 = 1'b1; step(); step(); idle_inputs();

    // 0x81 read out LSB first, then filler after the eighth bit.
    joy0 = 8'h81; strobe = 1'b1; step(); strobe = 1'b0; step();
    repeat (9) begin rd0 = 1'b1; step(); rd0 = 1'b0; step(); end

    // Reads while strobe is high never shift; the load tracks joy0.
    joy0 = 8'h01; strobe = 1'b1; step();
    repeat (3) begin rd0 = 1'b1; step(); end
    rd0 = 1'b0; joy0 = 8'h00; step(); step(); idle_inputs(); step();

    // Power pad button 1 on port 1.
    powerpad_en = 1'b1; powerpad = 12'h001; strobe = 1'b1; step(); strobe = 1'b0;
    repeat (8) begin rd1 = 1'b1; step(); end
    idle_inputs(); powerpad_en = 1'b0; step();

    // Simultaneous reads on both ports, rd held high.
    joy0 = 8'h0F; joy1 = 8'hF0; strobe = 1'b1; step(); strobe = 1'b0;
    rd0 = 1'b1; rd1 = 1'b1; repeat (8) step(); idle_inputs(); step();

    // Reset mid-sequence discards remaining bits.
    joy0 = 8'h00; strobe = 1'b1; step(); strobe = 1'b0;
    repeat (3) begin rd0 = 1'b1; step(); end
    rd0 = 1'b0; reset_n = 1'b0; strobe = 1'b1; step(); reset_n = 1'b1; strobe = 1'b0;
    repeat (3) begin rd0 = 1'b1; step(); end
    idle_inputs(); step();

    // Strobe rising together with a read after five reads.
    joy0 = 8'hA6; strobe = 1'b1; step(); strobe = 1'b0;
    repeat (5) begin rd0 = 1'b1; step(); end
    joy0 = 8'h5B; strobe = 1'b1; rd0 = 1'b1; step();
    strobe = 1'b0; rd0 = 1'b0; joy0 = 8'h00; step();
    repeat (9) begin rd0 = 1'b1; step(); end
    idle_inputs(); step();

    // Randomized traffic: occasional strobes and resets, frequent reads,
    // buttons changing underneath in-progress sequences.
    repeat (3000) begin
      reset_n     = ($urandom_range(0, 199) != 0);
      strobe      = ($urandom_range(0, 11) == 0);
      rd0         = ($urandom_range(0, 1) == 1);
      rd1         = ($urandom_range(0, 1) == 1);
      joy0        = 8'($urandom);
      joy1        = 8'($urandom);
      powerpad    = 12'($urandom);
      if ($urandom_range(0, 15) == 0) powerpad_en = ~powerpad_en;
      step();
    end

    reset_n = 1'b1; idle_inputs(); step();
    #4;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
